reg_loader: RTL and testbench
=============================

REG_LOADER -- requirements
Module: reg_loader

Interface
REQ-001 Parameter W, default 8, data path width (register width).
REQ-002 Parameter D, default 4, register pointer width (2**D registers; address 0 not writable).
REQ-003 Port CLK  input  1  rising-edge clock; the block uses one clock only.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port start  input  1  single-cycle request to begin a block load.
REQ-006 Port base_addr  input  D  first destination register, sampled with start.
REQ-007 Port count  input  D  number of registers to load, sampled with start; 0 means none.
REQ-008 Port in_valid  input  1  upstream byte stream valid.
REQ-009 Port in_data  input  W  upstream byte stream data.
REQ-010 Port in_ready  output  1  loader accepts in_data this cycle.
REQ-011 Port cpu_write_en  input  1  processor write-back strobe.
REQ-012 Port cpu_waddr  input  D  processor write-back address.
REQ-013 Port cpu_data  input  W  processor write-back data.
REQ-014 Port cpu_stall  output  1  processor write-back blocked this cycle.
REQ-015 Port rf_write_en  output  1  register-file write strobe.
REQ-016 Port rf_waddr  output  D  register-file write address.
REQ-017 Port rf_data  output  W  register-file write data.
REQ-018 Port busy  output  1  high in LOAD and DONE states.
REQ-019 Port done  output  1  one-cycle pulse at load completion.

Function
REQ-020 FSM states: IDLE, LOAD, DONE; state register updates on rising CLK only.
REQ-021 IDLE: start=1 latches base_addr into cur_addr and count into remaining; next state LOAD if count!=0, else DONE.
REQ-022 Latching: base_addr==0 loads cur_addr=1 (address 0 is never a write target).
REQ-023 LOAD: in_ready=1; a beat occurs when in_valid && in_ready.
REQ-024 Beat: same-cycle combinational rf_write_en=1, rf_waddr=cur_addr, rf_data=in_data.
REQ-025 Beat: next cycle remaining decrements by 1; cur_addr increments, wrapping 2**D-1 -> 1 (skips 0).
REQ-026 Beat with remaining==1: next state DONE; no further in_ready that cycle's successor.
REQ-027 LOAD with in_valid=0: no write, state/counters hold; no timeout.
REQ-028 DONE: done=1 for exactly one cycle, in_ready=0, next state IDLE.
REQ-029 IDLE: in_ready=0; rf_* pass through cpu_* combinationally, except rf_write_en=0 when cpu_waddr==0.
REQ-030 LOAD and DONE: cpu_stall = cpu_write_en; processor writes are never forwarded to rf_*.
REQ-031 IDLE: cpu_stall=0.
REQ-032 start while busy=1 is ignored; base_addr/count are not resampled.
REQ-033 start and cpu_write_en together in IDLE: the cpu write is forwarded that cycle, then loading begins.
REQ-034 Latency: start at cycle n -> first possible write at cycle n+1; done at cycle after last beat.
REQ-035 No byte is ever dropped: every beat produces exactly one rf write.

Reset
REQ-036 reset=1 at a rising edge forces state IDLE, cur_addr=0, remaining=0; reset has priority over start and beats.
REQ-037 After reset: in_ready=0, busy=0, done=0, cpu_stall=0, rf_* follow cpu_* pass-through.
REQ-038 Reset mid-LOAD aborts the load with no done pulse; registers already written are not reverted.

Verification
REQ-039 start, base_addr=4, count=3, stream 0xA1,0xA2,0xA3 back-to-back -> writes r4=0xA1, r5=0xA2, r6=0xA3 at cycles n+1..n+3, done at n+4.
REQ-040 start, base_addr=14, count=3, stream 0x11,0x22,0x33 -> writes r14, r15, r1 (0 skipped), done pulse once.
REQ-041 start, base_addr=0, count=0 -> no rf write, DONE next cycle, done pulse, back to IDLE; base 0 count 1 -> write r1.
REQ-042 count=2 with in_valid gaps of 3 idle cycles, cpu_write_en=1 throughout -> cpu_stall=1 during LOAD/DONE, only loader writes reach rf_*.
REQ-043 reset asserted after first of 3 beats -> IDLE next cycle, no done, r(base) holds written byte, pass-through resumes.
REQ-044 IDLE cpu_write_en=1, cpu_waddr=0, cpu_data=0x5A -> rf_write_en=0; cpu_waddr=7 -> rf_write_en=1, rf_waddr=7, rf_data=0x5A.

Source files
------------

// File: rtl/reg_loader.sv
// reg_loader
//   Moves a block of W-bit words from an upstream valid/ready stream into
//   consecutive register-file entries. Processor write-back traffic shares
//   the same register-file write port. When idle, processor writes pass
//   straight through to the port. While a block load is in progress,
//   processor writes are stalled.
//
// Parameters
//   W : data / register width
//   D : register pointer width (2**D registers, register 0 is never written)
//
// Ports
//   CLK, reset                   rising-edge clock, synchronous active-high reset
//   start, base_addr, count      block-load request; base/count sampled with start
//   in_valid, in_data, in_ready  upstream word stream
//   cpu_write_en/waddr/data      processor write-back request
//   cpu_stall                    processor write-back blocked this cycle
//   rf_write_en/waddr/data       register-file write port
//   busy                         load in progress (LOAD or DONE)
//   done                         one-cycle pulse when a load completes
module reg_loader #(
    parameter int W = 8,
    parameter int D = 4
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic         start,
    input  logic [D-1:0] base_addr,
    input  logic [D-1:0] count,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    input  logic         cpu_write_en,
    input  logic [D-1:0] cpu_waddr,
    input  logic [W-1:0] cpu_data,
    output logic         cpu_stall,
    output logic         rf_write_en,
    output logic [D-1:0] rf_waddr,
    output logic [W-1:0] rf_data,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state;
    logic [D-1:0] cur_addr;
    logic [D-1:0] remaining;
    logic         beat;

    // Address after a, wrapping from the top register to 1 so that
    // register 0 is never a load target.
    function automatic logic [D-1:0] next_addr(input logic [D-1:0] a);
        logic [D-1:0] n;
        if (a == {D{1'b1}}) n = D'(1);
        else                n = a + D'(1);
        return n;
    endfunction

    // A base of 0 is promoted to 1 for the same reason.
    function automatic logic [D-1:0] first_addr(input logic [D-1:0] a);
        logic [D-1:0] f;
        if (a == '0) f = D'(1);
        else         f = a;
        return f;
    endfunction

    assign beat = (state == LOAD) && in_valid;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cur_addr  <= first_addr(base_addr);
                        remaining <= count;
                        state     <= (count != '0) ? LOAD : DONE;
                    end
                end
                LOAD: begin
                    if (beat) begin
                        cur_addr  <= next_addr(cur_addr);
                        remaining <= remaining - D'(1);
                        if (remaining == D'(1)) state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Status outputs decode directly from the state register.
    assign in_ready  = (state == LOAD);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign cpu_stall = busy && cpu_write_en;

    // The register-file port is owned by the processor in IDLE and by the
    // loader otherwise. In DONE, nothing is written.
    always_comb begin
        rf_write_en = 1'b0;
        rf_waddr    = cur_addr;
        rf_data     = in_data;
        case (state)
            IDLE: begin
                rf_write_en = cpu_write_en && (cpu_waddr != '0);
                rf_waddr    = cpu_waddr;
                rf_data     = cpu_data;
            end
            LOAD: begin
                rf_write_en = beat;
                rf_waddr    = cur_addr;
                rf_data     = in_data;
            end
            default: begin
                rf_write_en = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_reg_loader.sv
module tb_reg_loader;

    localparam int W = 8;
    localparam int D = 4;

    logic         CLK = 1'b0;
    logic         reset;
    logic         start;
    logic [D-1:0] base_addr;
    logic [D-1:0] count;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_ready;
    logic         cpu_write_en;
    logic [D-1:0] cpu_waddr;
    logic [W-1:0] cpu_data;
    logic         cpu_stall;
    logic         rf_write_en;
    logic [D-1:0] rf_waddr;
    logic [W-1:0] rf_data;
    logic         busy;
    logic         done;

    reg_loader #(.W(W), .D(D)) dut (
        .CLK(CLK), .reset(reset), .start(start), .base_addr(base_addr),
        .count(count), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .cpu_write_en(cpu_write_en),
        .cpu_waddr(cpu_waddr), .cpu_data(cpu_data), .cpu_stall(cpu_stall),
        .rf_write_en(rf_write_en), .rf_waddr(rf_waddr), .rf_data(rf_data),
        .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [D-1:0] a;
        logic [W-1:0] d;
    } wr_t;

    wr_t          exp_q[$];
    wr_t          mon_e;
    logic [W-1:0] regs [2**D];
    int           n_cmp = 0;
    int           n_bad = 0;
    int           done_cnt = 0;
    int           done_base;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [D-1:0] a, input logic [W-1:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    // Inputs change 1 time unit after a rising edge; checks happen at 3.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // Monitor: every register-file write must match the next expected one.
    always @(negedge CLK) begin
        if (rf_write_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got addr %0d data %0h expected no write",
                         rf_waddr, rf_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(rf_waddr), 32'(mon_e.a));
                check("wr_data", 32'(rf_data), 32'(mon_e.d));
                regs[rf_waddr] = rf_data;
            end
        end
        if (done === 1'b1) done_cnt++;
    end

    initial begin
        for (int i = 0; i < 2**D; i++) regs[i] = '0;
        reset = 1'b1; start = 1'b0; base_addr = '0; count = '0;
        in_valid = 1'b0; in_data = '0;
        cpu_write_en = 1'b0; cpu_waddr = '0; cpu_data = '0;
        tick(); tick();
        reset = 1'b0;
        settle();
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_cpu_stall", 32'(cpu_stall), 0);
        tick();

        // Block load base 4, count 3, back-to-back words.
        done_base = done_cnt;
        start = 1'b1; base_addr = 4'd4; count = 4'd3;
        tick();
        start = 1'b0;
        settle();
        check("t1_in_ready", 32'(in_ready), 1);
        check("t1_busy", 32'(busy), 1);
        in_valid = 1'b1; in_data = 8'hA1; expect_wr(4'd4, 8'hA1); tick();
        in_data = 8'hA2; expect_wr(4'd5, 8'hA2); tick();
        in_data = 8'hA3; expect_wr(4'd6, 8'hA3); tick();
        in_valid = 1'b0;
        settle();
        check("t1_done", 32'(done), 1);
        check("t1_in_ready_done", 32'(in_ready), 0);
        tick();
        settle();
        check("t1_done_low", 32'(done), 0);
        check("t1_busy_low", 32'(busy), 0);
        check("t1_done_cnt", 32'(done_cnt - done_base), 1);
        check("t1_drained", 32'(exp_q.size()), 0);

        // Base 14, count 3: wraps 15 -> 1. A second start mid-load is ignored.
        done_base = done_cnt;
        start = 1'b1; base_addr = 4'd14; count = 4'd3;
        tick();
        in_valid = 1'b1; in_data = 8'h11; expect_wr(4'd14, 8'h11);
        base_addr = 4'd2; count = 4'd5;
        tick();
        start = 1'b0;
        in_data = 8'h22; expect_wr(4'd15, 8'h22); tick();
        in_data = 8'h33; expect_wr(4'd1, 8'h33); tick();
        in_valid = 1'b0;
        tick(); tick();
        settle();
        check("t2_done_cnt", 32'(done_cnt - done_base), 1);
        check("t2_idle", 32'(busy), 0);
        check("t2_drained", 32'(exp_q.size()), 0);

        // Base 0, count 0: straight to DONE with no write.
        done_base = done_cnt;
        start = 1'b1; base_addr = 4'd0; count = 4'd0;
        tick();
        start = 1'b0;
        settle();
        check("t3_done", 32'(done), 1);
        check("t3_in_ready", 32'(in_ready), 0);
        tick();
        settle();
        check("t3_idle", 32'(busy), 0);
        check("t3_done_cnt", 32'(done_cnt - done_base), 1);
        // Base 0, count 1: writes register 1.
        start = 1'b1; base_addr = 4'd0; count = 4'd1;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 8'h77; expect_wr(4'd1, 8'h77); tick();
        in_valid = 1'b0;
        settle();
        check("t3b_done", 32'(done), 1);
        tick();
        check("t3b_drained", 32'(exp_q.size()), 0);

        // Count 2 with gaps while the processor keeps writing.
        done_base = done_cnt;
        cpu_write_en = 1'b1; cpu_waddr = 4'd3; cpu_data = 8'hEE;
        start = 1'b1; base_addr = 4'd9; count = 4'd2;
        expect_wr(4'd3, 8'hEE);
        tick();
        start = 1'b0;
        for (int b = 0; b < 2; b++) begin
            for (int g = 0; g < 3; g++) begin
                settle();
                check("t4_stall_gap", 32'(cpu_stall), 1);
                check("t4_ready_gap", 32'(in_ready), 1);
                tick();
            end
            in_valid = 1'b1; in_data = 8'hD1 + 8'(b);
            expect_wr(4'd9 + 4'(b), 8'hD1 + 8'(b));
            tick();
            in_valid = 1'b0;
        end
        settle();
        check("t4_done", 32'(done), 1);
        check("t4_stall_done", 32'(cpu_stall), 1);
        tick();
        cpu_write_en = 1'b0;
        settle();
        check("t4_stall_idle", 32'(cpu_stall), 0);
        check("t4_done_cnt", 32'(done_cnt - done_base), 1);
        check("t4_drained", 32'(exp_q.size()), 0);

        // Reset after the first of three words aborts without a done pulse.
        done_base = done_cnt;
        start = 1'b1; base_addr = 4'd5; count = 4'd3;
        tick();
        start = 1'b0;
        in_valid = 1'b1; in_data = 8'h41; expect_wr(4'd5, 8'h41); tick();
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        check("t5_busy", 32'(busy), 0);
        check("t5_in_ready", 32'(in_ready), 0);
        check("t5_done", 32'(done), 0);
        check("t5_reg_kept", 32'(regs[5]), 32'h41);
        tick(); tick();
        check("t5_no_done", 32'(done_cnt - done_base), 0);

        // Idle pass-through; address 0 is filtered.
        cpu_write_en = 1'b1; cpu_waddr = 4'd0; cpu_data = 8'h5A;
        settle();
        check("t6_wen_addr0", 32'(rf_write_en), 0);
        check("t6_stall", 32'(cpu_stall), 0);
        tick();
        cpu_waddr = 4'd7; expect_wr(4'd7, 8'h5A);
        settle();
        check("t6_wen", 32'(rf_write_en), 1);
        check("t6_waddr", 32'(rf_waddr), 7);
        check("t6_data", 32'(rf_data), 32'h5A);
        tick();
        cpu_write_en = 1'b0;
        tick();
        check("final_drained", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
